// File: rtl/mips_fetch_pkg.sv
// Shared constants, types and helpers for the MIPS instruction-fetch stage.
// Imported by the fetch top and by the jump predecoder.
package mips_fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 30;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [5:0]  OP_JAL    = 6'b000011;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    // Source of the next PC / IF-ID contents when not in reset.
    typedef enum logic [1:0] {
        SelAdvance,
        SelHold,
        SelRedirect
    } fetch_sel_e;

    // Word address to byte address. Low two bits are always zero.
    function automatic logic [31:0] word_to_byte(input logic [ADDR_W_DEF-1:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/mod_jump_predecode.sv
// Combinational J/JAL predecoder: flags jumps and forms the absolute jump target
// from the 26-bit instruction index and the region bits of pc_plus1.
module mod_jump_predecode
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] instruction,
    input  logic [ADDR_W-1:0] pc_plus1,
    output logic              is_jump,
    output logic [ADDR_W-1:0] jump_target
);

    localparam logic [ADDR_W-1:0] INDEX_MASK = ADDR_W'(27'h3FF_FFFF);

    logic [5:0] opcode;

    assign opcode = instruction[DATA_W-1 -: 6];

    // Unknown opcodes fall through to default, so X data behaves as a non-jump NOP.
    always_comb begin
        is_jump = 1'b0;
        case (opcode)
            OP_J, OP_JAL: is_jump = 1'b1;
            default:      is_jump = 1'b0;
        endcase
    end

    // Keep the 256MB region of the sequential PC, replace the word index.
    assign jump_target = (pc_plus1 & ~INDEX_MASK) | ADDR_W'(instruction[25:0]);

endmodule

// File: rtl/mod_instruction_fetch.sv
// IF stage: PC register, ROM addressing, local J/JAL resolution and IF/ID register,
// with redirect (highest after reset), stall and synchronous active-low reset.
module mod_instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_instruction,
    output logic [DATA_W-1:0] if_id_instruction,
    output logic [31:0]       if_id_pc_plus4,
    output logic              if_id_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] jump_target;
    logic              is_jump;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [31:0]       pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;

    fetch_sel_e        sel;

    assign pc_plus1     = pc_q + ADDR_W'(1);
    assign imem_address = pc_q;

    mod_jump_predecode #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jump_predecode (
        .instruction (imem_instruction),
        .pc_plus1    (pc_plus1),
        .is_jump     (is_jump),
        .jump_target (jump_target)
    );

    // Redirect beats stall: the wrong-path fetch must be squashed even while held.
    always_comb begin
        sel = SelAdvance;
        if (redirect_valid) begin
            sel = SelRedirect;
        end else if (stall) begin
            sel = SelHold;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        unique case (sel)
            SelRedirect: begin
                pc_d    = redirect_target;
                instr_d = DATA_W'(INSTR_NOP);
                valid_d = 1'b0;
            end
            SelHold: begin
            end
            SelAdvance: begin
                pc_d       = is_jump ? jump_target : pc_plus1;
                instr_d    = imem_instruction;
                pc_plus4_d = word_to_byte(pc_plus1);
                valid_d    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= DATA_W'(INSTR_NOP);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc_plus4_q;
    assign if_id_valid       = valid_q;

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Bench for mod_instruction_fetch: directed plan steps plus randomized traffic,
// every cycle compared against an arithmetic model of the fetch stage.
module tb_mod_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [29:0] redirect_target;
    logic [29:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [64];

    // Reference model state.
    logic [29:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pp4;
    logic        m_valid;

    mod_instruction_fetch #(
        .ADDR_W   (30),
        .DATA_W   (32),
        .RESET_PC (30'd0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_address      (imem_address),
        .imem_instruction  (imem_instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: 64 populated words, everything else reads as 0.
    function automatic logic [31:0] rom_rd(input logic [29:0] a);
        if (a < 30'd64) return rom[a[5:0]];
        return 32'h0;
    endfunction

    task automatic refresh();
        imem_instruction = rom_rd(imem_address);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        logic [31:0] ins;
        logic [29:0] nxt;
        ins = rom_rd(m_pc);
        nxt = 30'((32'(m_pc) + 32'd1) % 32'h4000_0000);
        if (!rst_n) begin
            m_pc = 30'd0; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_inst = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            m_inst  = ins;
            m_pp4   = 32'(nxt) * 32'd4;
            m_valid = 1'b1;
            if ((ins / 32'h0400_0000) == 32'd2 || (ins / 32'h0400_0000) == 32'd3)
                m_pc = 30'((32'(nxt) & 32'h3C00_0000) | (ins & 32'h03FF_FFFF));
            else
                m_pc = nxt;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        refresh();
        check("model_pc",    32'(imem_address), 32'(m_pc));
        check("model_instr", if_id_instruction, m_inst);
        check("model_pp4",   if_id_pc_plus4,    m_pp4);
        check("model_valid", 32'(if_id_valid),  32'(m_valid));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        logic [5:0]  op;
        if ($urandom_range(0, 3) == 0) begin
            op = ($urandom_range(0, 1) == 0) ? 6'b000010 : 6'b000011;
            return {op, 26'($urandom_range(0, 63))};
        end
        v  = $urandom;
        op = v[31:26];
        if (op == 6'b000010 || op == 6'b000011) v[31:26] = 6'b001000;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        imem_instruction = 32'h0;
        for (int j = 0; j < 64; j++) rom[j] = 32'h0;
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h0485_FFFF;
        rom[2] = 32'h0800_0020;

        repeat (3) begin
            step();
            check("rst_addr",  32'(imem_address), 32'h0);
            check("rst_valid", 32'(if_id_valid),  32'h0);
            check("rst_instr", if_id_instruction, 32'h0);
        end

        rst_n = 1'b1;
        step();
        check("seq0_addr",  32'(imem_address), 32'h1);
        check("seq0_instr", if_id_instruction, 32'h0022_1820);
        check("seq0_pp4",   if_id_pc_plus4,    32'h4);
        check("seq0_valid", 32'(if_id_valid),  32'h1);
        step();
        check("seq1_addr",  32'(imem_address), 32'h2);
        check("seq1_instr", if_id_instruction, 32'h0485_FFFF);
        check("seq1_pp4",   if_id_pc_plus4,    32'h8);
        step();
        check("jmp_addr",  32'(imem_address), 32'h20);
        check("jmp_instr", if_id_instruction, 32'h0800_0020);
        check("jmp_pp4",   if_id_pc_plus4,    32'hC);
        step();
        check("tgt_valid", 32'(if_id_valid),  32'h1);
        check("tgt_instr", if_id_instruction, 32'h0);
        check("tgt_pp4",   if_id_pc_plus4,    32'h84);
        check("tgt_addr",  32'(imem_address), 32'h21);

        // Stall while pc==1.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        stall = 1'b1;
        repeat (2) begin
            step();
            check("stall_addr",  32'(imem_address), 32'h1);
            check("stall_instr", if_id_instruction, 32'h0022_1820);
            check("stall_pp4",   if_id_pc_plus4,    32'h4);
            check("stall_valid", 32'(if_id_valid),  32'h1);
        end
        stall = 1'b0;
        step();
        check("resume_addr",  32'(imem_address), 32'h2);
        check("resume_instr", if_id_instruction, 32'h0485_FFFF);

        // Redirect overrides stall.
        rom[16] = 32'h2108_0001;
        refresh();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 30'h10;
        step();
        check("redir_addr",  32'(imem_address), 32'h10);
        check("redir_valid", 32'(if_id_valid),  32'h0);
        check("redir_instr", if_id_instruction, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        check("redir_next_valid", 32'(if_id_valid),  32'h1);
        check("redir_next_instr", if_id_instruction, 32'h2108_0001);
        check("redir_next_pp4",   if_id_pc_plus4,    32'h44);

        // Redirect collides with a jump at pc==2.
        redirect_valid = 1'b1; redirect_target = 30'h2;
        step();
        redirect_target = 30'h5;
        step();
        check("coll_addr",  32'(imem_address), 32'h5);
        check("coll_valid", 32'(if_id_valid),  32'h0);
        redirect_valid = 1'b0;

        // PC wrap.
        redirect_valid = 1'b1; redirect_target = 30'h3FFF_FFFF;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_addr",  32'(imem_address), 32'h0);
        check("wrap_pp4",   if_id_pc_plus4,    32'h0);
        check("wrap_valid", 32'(if_id_valid),  32'h1);

        // Reset during stall.
        step();
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        check("rst_stall_addr",  32'(imem_address), 32'h0);
        check("rst_stall_valid", 32'(if_id_valid),  32'h0);
        check("rst_stall_instr", if_id_instruction, 32'h0);
        rst_n = 1'b1; stall = 1'b0;

        // Randomized traffic.
        for (int j = 0; j < 64; j++) rom[j] = rand_instr();
        refresh();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                rom[$urandom_range(0, 63)] = rand_instr();
                refresh();
            end
            rst_n           = ($urandom_range(0, 29) != 0);
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 5) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF
                                                          : 30'($urandom_range(0, 63));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_instruction_fetch.md
Name: mod_instruction_fetch

Overview:
- IF stage of the MIPS pipeline. Holds the program counter (PC) and drives the word address into the combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Resolves J/JAL locally with zero bubble. Accepts branch/exception redirects from later stages, plus stall and flush control from the hazard unit.

Parameters:
- ADDR_W, 30, word-address width (byte PC bits [31:2]).
- DATA_W, 32, instruction width.
- RESET_PC, 30'd0, word address loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  input  1  later stage resolved a taken branch or jr; overrides stall.
- redirect_target  input  ADDR_W  word address to fetch next when redirect_valid=1.
- imem_address  output  ADDR_W  word address to ROM; equals the PC register (combinational from it).
- imem_instruction  input  DATA_W  ROM data, valid the same cycle as imem_address.
- if_id_instruction  output  DATA_W  registered instruction for decode.
- if_id_pc_plus4  output  32  registered byte address of fetched instruction + 4 (link/branch base).
- if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc <= RESET_PC.
  - if_id_instruction <= 32'h0 (NOP).
  - if_id_pc_plus4 <= 0.
  - if_id_valid <= 0.
  - Reset dominates every other input. Reset mid-stall or mid-redirect discards all pending state.
- Combinational per cycle:
  - pc_plus1 = pc + 1, modulo 2^ADDR_W. 30'h3FFFFFFF wraps to 0 without an error flag.
  - opcode = imem_instruction[31:26].
  - is_jump = (opcode==6'b000010 || opcode==6'b000011).
  - jump_target = {pc_plus1[29:26], imem_instruction[25:0]}.
- Next-state priority per rising edge, highest first:
  1. Reset: as above.
  2. redirect_valid=1:
     - pc <= redirect_target.
     - if_id_valid <= 0; if_id_instruction <= NOP. The wrong-path fetch is squashed.
     - Stall is ignored.
  3. stall=1: pc, if_id_instruction, if_id_pc_plus4 and if_id_valid all hold.
  4. Normal:
     - if_id_instruction <= imem_instruction.
     - if_id_pc_plus4 <= {pc_plus1, 2'b00}.
     - if_id_valid <= 1.
     - pc <= is_jump ? jump_target : pc_plus1.
- Latency: instruction at address A appears on if_id_instruction one cycle after pc==A.
- No branch delay slot: the fetch after J is the jump target, with no bubble.
- The J/JAL instruction itself is forwarded to decode with valid=1. JAL link uses if_id_pc_plus4.
- Simultaneous redirect_valid and is_jump: redirect wins, and the jump is squashed.
- Stall with is_jump: no PC update. The jump is re-evaluated when the stall releases, because the ROM output is unchanged.
- The first fetch after reset release issues from RESET_PC. if_id_valid rises one cycle after the first non-reset edge.
- No X propagation: unknown ROM data (default 0) is treated as a NOP, which is not a jump.

Decomposition:
- Package mips_fetch_pkg:
  - OP_J = 6'b000010, OP_JAL = 6'b000011.
  - INSTR_NOP = 32'h0.
  - ADDR_W / DATA_W defaults.
  - Function for word-to-byte address conversion.
- One natural sub-module, mod_jump_predecode (combinational):
  - Inputs: instruction, pc_plus1.
  - Outputs: is_jump, jump_target.
  - Reused later by any predecode in the ID stage.
- PC register and IF/ID register stay in the top.

Test Plan:
- Reset sequencing: hold rst_n=0 for 3 cycles, with the ROM at word 0 holding 32'h00221820 (add), word 1 32'h0485FFFF, and word 2 32'h08000020 (j 0x20).
  - During reset: imem_address=0, if_id_valid=0, if_id_instruction=0.
  - After release: imem_address sequence 0,1,2,0x20 on consecutive cycles.
  - if_id_instruction sequence 00221820, 0485FFFF, 08000020 with pc_plus4 4, 8, 12.
- Jump with no bubble: the cycle after 08000020 enters IF/ID, if_id_valid=1 and the instruction is from word 0x20 (ROM default 0).
- Stall: assert stall for 2 cycles while pc==1. pc stays 1 and if_id holds 00221820/4/valid=1; fetch resumes at word 1 after release.
- Redirect over stall: while stall=1, assert redirect_valid with target 30'h10.
  - Next cycle: pc=0x10, if_id_valid=0, if_id_instruction=0.
  - The following cycle: valid=1 with word 0x10 data.
- Redirect vs jump collision: while pc==2 (ROM returns j 0x20), assert redirect_valid with target 30'h5. Next pc=5, not 0x20, and if_id_valid=0.
- Wrap and mid-operation reset:
  - Set pc=30'h3FFFFFFF via redirect. Next pc=0 and if_id_pc_plus4=32'h00000000.
  - Assert rst_n=0 during a stall. pc returns to RESET_PC and if_id_valid=0 on that edge.
